// File: rtl/axi_rd_line_master.sv
// Read-only AXI4 master: turns a single-word or cache-line read request into one AR burst
// and streams the R beats back. Minimal ariane_soc/ariane_axi type packages included for a standalone build.
package ariane_soc;
    localparam int unsigned IdWidth = 4;
endpackage

package ariane_axi;
    localparam int unsigned IdWidth = ariane_soc::IdWidth;

    typedef enum logic {SINGLE_REQ, CACHE_LINE_REQ} ad_req_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
        logic               lock;
        logic [3:0]         cache;
        logic [2:0]         prot;
        logic [3:0]         qos;
        logic [3:0]         region;
        logic [5:0]         atop;
        logic               user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
        logic               user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
        logic               lock;
        logic [3:0]         cache;
        logic [2:0]         prot;
        logic [3:0]         qos;
        logic [3:0]         region;
        logic               user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        data;
        logic [1:0]         resp;
        logic               last;
        logic               user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_rd_line_master #(
    parameter int unsigned                    LINE_WORDS = 4,
    parameter logic [ariane_soc::IdWidth-1:0] AXI_ID     = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_i,
    input  ariane_axi::ad_req_t             type_i,
    input  logic [63:0]                     addr_i,
    output logic                            gnt_o,
    output logic                            valid_o,
    output logic [63:0]                     rdata_o,
    output logic [$clog2(LINE_WORDS)-1:0]   beat_o,
    output logic                            last_o,
    output logic                            err_o,
    output ariane_axi::req_t                axi_req_o,
    input  ariane_axi::resp_t               axi_resp_i
);
    localparam int unsigned BW  = $clog2(LINE_WORDS);
    localparam int unsigned OFF = BW + 3;

    typedef enum logic [1:0] {IDLE, AR, RDATA} state_e;

    state_e        state_q, state_d;
    logic [63:0]   addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          ar_hs, r_beat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ar_hs   = 1'b0;
        r_beat  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = AR;
                    if (type_i == ariane_axi::CACHE_LINE_REQ) begin
                        addr_d = {addr_i[63:OFF], OFF'(0)};
                        len_d  = 8'(LINE_WORDS - 1);
                    end else begin
                        addr_d = addr_i;
                        len_d  = 8'd0;
                    end
                end
            end
            AR: begin
                ar_hs = axi_resp_i.ar_ready;
                if (ar_hs) state_d = RDATA;
            end
            RDATA: begin
                r_beat = axi_resp_i.r_valid;
                // Only r.last ends the burst; the index saturates on over-long bursts.
                if (r_beat) begin
                    if (axi_resp_i.r.last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != BW'(LINE_WORDS - 1)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_o   = ar_hs;
    assign valid_o = r_beat;
    assign rdata_o = r_beat ? axi_resp_i.r.data : '0;
    assign err_o   = r_beat & axi_resp_i.r.resp[1];
    assign last_o  = r_beat & axi_resp_i.r.last;
    assign beat_o  = cnt_q;

    // Valid/ready come straight from the state register so reset drops them asynchronously.
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.b_ready  = 1'b1;
        axi_req_o.ar_valid = (state_q == AR);
        axi_req_o.r_ready  = (state_q == RDATA);
        axi_req_o.ar.id    = AXI_ID;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.len   = len_q;
        axi_req_o.ar.size  = 3'd3;
        axi_req_o.ar.burst = 2'b01;
    end

    logic unused_resp;
    assign unused_resp = ^{axi_resp_i.aw_ready, axi_resp_i.w_ready, axi_resp_i.b_valid,
                           axi_resp_i.b, axi_resp_i.r.id, axi_resp_i.r.resp[0], axi_resp_i.r.user};
endmodule

// File: tb/tb_axi_rd_line_master.sv
// Bench for axi_rd_line_master: table of directed transactions, reset/back-to-back sequences,
// then random transactions checked against a transaction-level model of the read rules.
module tb_axi_rd_line_master;
    localparam int LW = 4;
    localparam logic [3:0] ID = 4'h5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req = 1'b0;
    ariane_axi::ad_req_t typ = ariane_axi::SINGLE_REQ;
    logic [63:0]         addr = '0;
    logic                gnt, vld, last, err;
    logic [63:0]         rdata;
    logic [1:0]          beat;
    ariane_axi::req_t    axi_req;
    ariane_axi::resp_t   axi_resp = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_rd_line_master #(.LINE_WORDS(LW), .AXI_ID(ID)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .type_i(typ), .addr_i(addr),
        .gnt_o(gnt), .valid_o(vld), .rdata_o(rdata), .beat_o(beat), .last_o(last),
        .err_o(err), .axi_req_o(axi_req), .axi_resp_i(axi_resp)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 128'(vld), 128'(0));
        chk({tag, "_last"}, 128'(last), 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
        chk({tag, "_gnt"}, 128'(gnt), 128'(0));
        chk({tag, "_beat"}, 128'(beat), 128'(0));
        chk({tag, "_rdata"}, 128'(rdata), 128'(0));
        chk({tag, "_ar_valid"}, 128'(axi_req.ar_valid), 128'(0));
        chk({tag, "_r_ready"}, 128'(axi_req.r_ready), 128'(0));
        chk({tag, "_wr_tie"}, 128'({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready}), 128'(3'b001));
        chk({tag, "_aw_w_zero"}, 128'({axi_req.aw, axi_req.w} != '0), 128'(0));
    endtask

    // One full transaction acting as the AXI slave. Called between a negedge and the next posedge.
    task automatic run_txn(input logic ln, input logic [63:0] a, input logic [63:0] ea,
                           input logic [7:0] el, input int nbeats, input int ar_dly,
                           input logic [31:0] gaps, input int err_beat, input logic keep,
                           input int rst_at);
        logic [63:0] d;
        logic [1:0]  rs;
        logic        rv;
        int          k;
        int          c;
        req  = 1'b1;
        typ  = ln ? ariane_axi::CACHE_LINE_REQ : ariane_axi::SINGLE_REQ;
        addr = a;
        @(posedge clk); #1;
        for (int i = 0; i <= ar_dly; i++) begin
            axi_resp.ar_ready = (i == ar_dly);
            axi_resp.b_valid  = 1'($urandom);
            if (i > 0) addr = {$urandom, $urandom};
            @(negedge clk);
            chk("ar_valid", 128'(axi_req.ar_valid), 128'(1));
            chk("ar_addr", 128'(axi_req.ar.addr), 128'(ea));
            chk("ar_len", 128'(axi_req.ar.len), 128'(el));
            chk("gnt", 128'(gnt), 128'(i == ar_dly));
            chk("r_ready_in_ar", 128'(axi_req.r_ready), 128'(0));
            chk("valid_in_ar", 128'(vld), 128'(0));
            if (i == ar_dly)
                chk("ar_fields", 128'({axi_req.ar.id, axi_req.ar.size, axi_req.ar.burst, axi_req.ar.lock,
                                       axi_req.ar.cache, axi_req.ar.prot, axi_req.ar.qos, axi_req.ar.region}),
                    128'({ID, 3'd3, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0}));
            @(posedge clk); #1;
        end
        axi_resp.ar_ready = 1'b0;
        if (!keep) req = 1'b0;
        k = 0;
        c = 0;
        while (k < nbeats && c < 200) begin
            rv = (c >= 32) ? 1'b1 : gaps[c];
            d  = {$urandom, $urandom};
            rs = (err_beat >= 0) ? ((k == err_beat) ? 2'b10 : 2'b00) : 2'($urandom);
            axi_resp.r_valid = rv;
            axi_resp.r.data  = d;
            axi_resp.r.resp  = rs;
            axi_resp.r.last  = (k == nbeats - 1);
            axi_resp.b_valid = 1'($urandom);
            if (rst_at >= 0 && k == rst_at && rv) begin
                #1 rst_n = 1'b0;
                #1;
                chk_quiet("mid_rst");
                return;
            end
            @(negedge clk);
            chk("r_ready", 128'(axi_req.r_ready), 128'(1));
            chk("ar_valid_in_r", 128'(axi_req.ar_valid), 128'(0));
            chk("gnt_in_r", 128'(gnt), 128'(0));
            chk("valid", 128'(vld), 128'(rv));
            if (rv) begin
                chk("rdata", 128'(rdata), 128'(d));
                chk("beat", 128'(beat), 128'((k < LW) ? k : LW - 1));
                chk("last", 128'(last), 128'(k == nbeats - 1));
                chk("err", 128'(err), 128'(rs[1]));
                k++;
            end
            c++;
            @(posedge clk); #1;
        end
        chk("burst_done", 128'(k), 128'(nbeats));
        axi_resp.r_valid = 1'b0;
        axi_resp.r.last  = 1'b0;
        @(negedge clk);
        chk_quiet("post_last");
    endtask

    typedef struct {
        logic        ln;
        logic [63:0] a;
        logic [63:0] ea;
        logic [7:0]  el;
        int          nb;
        int          dly;
        logic [31:0] gaps;
        int          eb;
        logic        keep;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic        ln;
        logic [63:0] a, ea;
        logic [7:0]  el;
        tbl[0] = '{1'b0, 64'h8000_0018, 64'h8000_0018, 8'd0, 1, 0, 32'hFFFF_FFFF, -1, 1'b0};
        tbl[1] = '{1'b1, 64'h8000_0038, 64'h8000_0020, 8'd3, 4, 0, 32'hFFFF_FFED, -1, 1'b0};
        tbl[2] = '{1'b1, 64'h8000_0000, 64'h8000_0000, 8'd3, 4, 5, 32'hFFFF_FFFF, -1, 1'b0};
        tbl[3] = '{1'b1, 64'h8000_0058, 64'h8000_0040, 8'd3, 4, 1, 32'hFFFF_FFFF, 2, 1'b0};
        tbl[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE0, 8'd3, 6, 0, 32'hFFFF_FFFF, -1, 1'b0};
        tbl[5] = '{1'b1, 64'h1234_5678_9ABC_DEF8, 64'h1234_5678_9ABC_DEE0, 8'd3, 2, 0, 32'hFFFF_FFF5, -1, 1'b0};
        tbl[6] = '{1'b0, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0007, 8'd0, 1, 2, 32'hFFFF_FFFF, -1, 1'b1};
        tbl[7] = '{1'b0, 64'h8000_0100, 64'h8000_0100, 8'd0, 1, 0, 32'hFFFF_FFFF, -1, 1'b1};
        tbl[8] = '{1'b1, 64'h8000_0108, 64'h8000_0100, 8'd3, 4, 0, 32'hFFFF_FFFF, -1, 1'b0};

        #3;
        chk_quiet("reset");
        #19 rst_n = 1'b1;

        for (int t = 0; t < 9; t++)
            run_txn(tbl[t].ln, tbl[t].a, tbl[t].ea, tbl[t].el, tbl[t].nb, tbl[t].dly,
                    tbl[t].gaps, tbl[t].eb, tbl[t].keep, -1);

        // Reset while beat 2 of a line fill is on the bus, then a clean single read.
        run_txn(1'b1, 64'h8000_0200, 64'h8000_0200, 8'd3, 4, 0, 32'hFFFF_FFFF, -1, 1'b0, 2);
        axi_resp.r_valid = 1'b0;
        axi_resp.r.last  = 1'b0;
        req = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("after_rst");
        run_txn(1'b0, 64'h8000_0210, 64'h8000_0210, 8'd0, 1, 0, 32'hFFFF_FFFF, -1, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            ln = 1'($urandom);
            a  = {$urandom, $urandom};
            ea = ln ? (a & ~(64'(LW) * 64'd8 - 64'd1)) : a;
            el = ln ? 8'(LW - 1) : 8'd0;
            run_txn(ln, a, ea, el, ln ? $urandom_range(1, LW + 2) : $urandom_range(1, 2),
                    $urandom_range(0, 4), $urandom | $urandom, -1, 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_rd_line_master.md
Name: axi_rd_line_master

Overview:
- Read-only AXI4 master that turns a simple core-side read request into an AXI AR transaction plus R-beat collection.
- Supports the `ariane_axi::ad_req_t` request types: SINGLE_REQ (one 64-bit word) and CACHE_LINE_REQ (full line burst).
- Drives `ariane_axi::req_t` and consumes `ariane_axi::resp_t`; it sits directly upstream of the AXI crossbar master port, feeding the request/response structs.
- The write channels are tied off.

Parameters:
- LINE_WORDS, 4, number of 64-bit beats per cache line; power of two, 2..16.
- AXI_ID, 0, ID driven on AR; width `ariane_soc::IdWidth`.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  read request; held high until gnt_o.
- type_i  in  ad_req_t  SINGLE_REQ or CACHE_LINE_REQ; sampled with req_i.
- addr_i  in  64  byte address; sampled with req_i.
- gnt_o  out  1  one-cycle pulse on AR handshake.
- valid_o  out  1  read beat valid.
- rdata_o  out  64  beat data.
- beat_o  out  $clog2(LINE_WORDS)  beat index in burst, 0-based.
- last_o  out  1  final beat of transaction.
- err_o  out  1  beat response was SLVERR/DECERR (resp[1]).
- axi_req_o  out  ariane_axi::req_t  AXI request struct.
- axi_resp_i  in  ariane_axi::resp_t  AXI response struct.

Behaviour:
- Clock/reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset state: FSM = IDLE. gnt_o, valid_o, last_o, err_o = 0; beat_o = 0; ar_valid = 0; r_ready = 0.
- Reset mid-operation: returns to IDLE immediately and ar_valid drops asynchronously. Outstanding R beats after reset are the fabric's concern.
- FSM states: IDLE, AR, RDATA.
- IDLE:
  - If req_i=1, register addr/type/len and go to AR next cycle.
  - SINGLE_REQ: addr as given, len=0.
  - CACHE_LINE_REQ: addr with low $clog2(LINE_WORDS)+3 bits zeroed, len=LINE_WORDS-1.
- AR:
  - ar_valid=1 with stable payload until ar_ready.
  - In the cycle ar_valid&ar_ready: gnt_o=1, then go to RDATA.
  - ar_valid is never withdrawn before handshake.
- RDATA:
  - r_ready=1.
  - Each cycle r_valid=1: valid_o=1 (combinational pass-through), rdata_o=r.data, err_o=r.resp[1], last_o=r.last, beat_o=current counter. The counter then increments.
  - On r_valid&r.last go to IDLE and clear the counter.
- Counter rules:
  - The counter saturates at LINE_WORDS-1 and never wraps.
  - The transaction ends only on r.last, even if the beat count mismatches.
- Errors: an error beat does not abort; the burst runs to r.last.
- Request timing:
  - Minimum latency is req_i at cycle 0, gnt_o at cycle 1, first beat at cycle 2.
  - req_i in AR/RDATA is ignored (no gnt); it is accepted in IDLE the cycle after the previous r.last.
- AR fields: id=AXI_ID, size=3 (8 B), burst=INCR (2'b01), lock=0, cache=0, prot=0, qos=0, region=0.
- Write channels: aw_valid=0, w_valid=0, b_ready=1 (stray B beats are drained). All aw/w payload is 0.
- Outside RDATA: r_ready=0 and valid_o=0.

Test Plan:
- SINGLE_REQ, addr=0x8000_0018, ar_ready=1 -> ar.addr=0x8000_0018, ar.len=0, gnt_o at cycle 1; R beat data 0xDEAD_BEEF, last=1 -> valid_o=1, beat_o=0, last_o=1, FSM IDLE next cycle.
- CACHE_LINE_REQ, addr=0x8000_0038, LINE_WORDS=4:
  - Expect ar.addr=0x8000_0020, len=3.
  - R beats with r_valid gaps (1,0,1,1,0,1) -> exactly 4 valid_o pulses, beat_o 0,1,2,3, last_o only on the 4th.
- AR stall, ar_ready low 5 cycles -> ar_valid held and payload stable, gnt_o pulses once on the handshake cycle, no r_ready before.
- Line fill with beat 2 resp=SLVERR -> err_o=1 on beat 2 only, burst completes, FSM IDLE after last.
- rst_ni low after beat 1 of a line fill -> all outputs 0 in the same cycle, FSM IDLE. A new SINGLE_REQ after release completes normally.
- Back-to-back: req_i held high across two requests -> second AR issued 1 cycle after first r.last. Stray B beat (b_valid=1) is accepted via b_ready=1 with no effect.
